// File: rtl/offset_search_ctrl_pkg.sv
// Shared widths, default search limits and FSM state encodings for offset_search_ctrl.
package offset_search_ctrl_pkg;

  localparam int unsigned MAX_OFFSET_WIDTH   = 2;
  localparam int unsigned FRAME_BITSUM_WIDTH = 10;

  localparam int unsigned DEF_X_MAX = (1 << MAX_OFFSET_WIDTH) - 1;
  localparam int unsigned DEF_Y_MAX = (1 << MAX_OFFSET_WIDTH) - 1;

  localparam logic [2:0] OSC_IDLE    = 3'd0;
  localparam logic [2:0] OSC_ISSUE   = 3'd1;
  localparam logic [2:0] OSC_WAIT    = 3'd2;
  localparam logic [2:0] OSC_UPDATE  = 3'd3;
  localparam logic [2:0] OSC_ADVANCE = 3'd4;
  localparam logic [2:0] OSC_FINISH  = 3'd5;
  localparam logic [2:0] OSC_DRAIN   = 3'd6;

endpackage

// File: rtl/min_sum_tracker.sv
// Running minimum of correlation sums with the offset that produced it (strict-less update).
module min_sum_tracker
  import offset_search_ctrl_pkg::*;
#(
  parameter int unsigned OFS_W = MAX_OFFSET_WIDTH,
  parameter int unsigned SUM_W = FRAME_BITSUM_WIDTH + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_sample_en,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [OFS_W-1:0] i_x,
  input  logic [OFS_W-1:0] i_y,
  output logic [SUM_W-1:0] o_run_min,
  output logic [OFS_W-1:0] o_run_x,
  output logic [OFS_W-1:0] o_run_y
);

  logic [SUM_W-1:0] r_min;
  logic [OFS_W-1:0] r_x;
  logic [OFS_W-1:0] r_y;

  // Strict compare keeps the earliest candidate in raster order on ties.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_min <= '1;
      r_x   <= '0;
      r_y   <= '0;
    end else if (i_clear) begin
      r_min <= '1;
      r_x   <= '0;
      r_y   <= '0;
    end else if (i_sample_en && (i_sum < r_min)) begin
      r_min <= i_sum;
      r_x   <= i_x;
      r_y   <= i_y;
    end
  end

  assign o_run_min = r_min;
  assign o_run_x   = r_x;
  assign o_run_y   = r_y;

endmodule

// File: rtl/offset_search_ctrl.sv
// Sweeps the correlator over every (x,y) offset and reports the minimum-sum offset.
// Optional build macro ZERO_SUM_EXIT_EN: a zero sum ends the sweep early.
module offset_search_ctrl
  import offset_search_ctrl_pkg::*;
#(
  parameter int unsigned OFS_W = MAX_OFFSET_WIDTH,
  parameter int unsigned SUM_W = FRAME_BITSUM_WIDTH + 1,
  parameter int unsigned X_MAX = (1 << OFS_W) - 1,
  parameter int unsigned Y_MAX = (1 << OFS_W) - 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_frame_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_corr_go,
  output logic [OFS_W-1:0] o_corr_x_offset,
  output logic [OFS_W-1:0] o_corr_y_offset,
  output logic             o_corr_frame_sel,
  input  logic [SUM_W-1:0] i_corr_sum,
  input  logic             i_corr_done,
  output logic [OFS_W-1:0] o_best_x,
  output logic [OFS_W-1:0] o_best_y,
  output logic [SUM_W-1:0] o_best_sum,
  output logic             o_result_valid
);

  localparam logic [OFS_W-1:0] L_X_MAX = OFS_W'(X_MAX);
  localparam logic [OFS_W-1:0] L_Y_MAX = OFS_W'(Y_MAX);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [OFS_W-1:0] r_x;
  logic [OFS_W-1:0] r_y;
  logic             r_frame_sel;
  logic [SUM_W-1:0] r_sample;
  logic [OFS_W-1:0] r_best_x;
  logic [OFS_W-1:0] r_best_y;
  logic [SUM_W-1:0] r_best_sum;
  logic             r_valid;
  logic [SUM_W-1:0] w_run_min;
  logic [OFS_W-1:0] w_run_x;
  logic [OFS_W-1:0] w_run_y;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == OSC_IDLE) && i_start;
  assign w_last   = (r_x == L_X_MAX) && (r_y == L_Y_MAX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OSC_IDLE:    if (i_start) w_state_nxt = OSC_ISSUE;
      OSC_ISSUE:   w_state_nxt = i_abort ? OSC_IDLE : OSC_WAIT;
      // Abort coinciding with done has nothing left in flight to drain.
      OSC_WAIT: begin
        if (i_abort)          w_state_nxt = i_corr_done ? OSC_IDLE : OSC_DRAIN;
        else if (i_corr_done) w_state_nxt = OSC_UPDATE;
      end
      OSC_UPDATE: begin
        if (i_abort) w_state_nxt = OSC_IDLE;
`ifdef ZERO_SUM_EXIT_EN
        else if (r_sample == '0) w_state_nxt = OSC_FINISH;
`endif
        else w_state_nxt = OSC_ADVANCE;
      end
      OSC_ADVANCE: begin
        if (i_abort)     w_state_nxt = OSC_IDLE;
        else if (w_last) w_state_nxt = OSC_FINISH;
        else             w_state_nxt = OSC_ISSUE;
      end
      OSC_FINISH:  w_state_nxt = OSC_IDLE;
      OSC_DRAIN:   if (i_corr_done) w_state_nxt = OSC_IDLE;
      default:     w_state_nxt = OSC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= OSC_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_sel <= 1'b0;
      r_sample    <= '0;
      r_best_x    <= '0;
      r_best_y    <= '0;
      r_best_sum  <= '1;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x         <= '0;
        r_y         <= '0;
        r_frame_sel <= i_frame_sel;
        r_valid     <= 1'b0;
      end
      if ((r_state == OSC_WAIT) && i_corr_done && !i_abort) r_sample <= i_corr_sum;
      if ((r_state == OSC_ADVANCE) && !i_abort && !w_last) begin
        if (r_x == L_X_MAX) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (r_state == OSC_FINISH) begin
        r_best_x   <= w_run_x;
        r_best_y   <= w_run_y;
        r_best_sum <= w_run_min;
        r_valid    <= 1'b1;
      end
    end
  end

  min_sum_tracker #(
    .OFS_W(OFS_W),
    .SUM_W(SUM_W)
  ) u_tracker (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_accept),
    .i_sample_en (r_state == OSC_UPDATE),
    .i_sum       (r_sample),
    .i_x         (r_x),
    .i_y         (r_y),
    .o_run_min   (w_run_min),
    .o_run_x     (w_run_x),
    .o_run_y     (w_run_y)
  );

  // Go is withheld on an abort in ISSUE so no correlator run is left orphaned.
  assign o_corr_go        = (r_state == OSC_ISSUE) && !i_abort;
  assign o_busy           = (r_state != OSC_IDLE);
  assign o_done           = (r_state == OSC_FINISH);
  assign o_corr_x_offset  = r_x;
  assign o_corr_y_offset  = r_y;
  assign o_corr_frame_sel = r_frame_sel;
  assign o_best_x         = r_best_x;
  assign o_best_y         = r_best_y;
  assign o_best_sum       = r_best_sum;
  assign o_result_valid   = r_valid;

endmodule

// File: tb/tb_offset_search_ctrl.sv
// Directed bench for offset_search_ctrl with a scripted, random-latency correlator model.
module tb_offset_search_ctrl;
  import offset_search_ctrl_pkg::*;

  localparam int OW = MAX_OFFSET_WIDTH;
  localparam int SW = FRAME_BITSUM_WIDTH + 1;

  logic          clk = 1'b0;
  logic          reset, start, abort, frame_sel;
  logic          busy, done, corr_go, corr_frame_sel, result_valid;
  logic [OW-1:0] corr_x, corr_y, best_x, best_y;
  logic [SW-1:0] best_sum;
  logic [SW-1:0] corr_sum;
  logic          corr_done;

  logic [SW-1:0] sums [16];
  logic          m_busy;
  int            m_cnt;
  int            go_cnt = 0;
  int            done_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            g0, d0;

  always #5 clk = ~clk;

  offset_search_ctrl dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_abort          (abort),
    .i_frame_sel      (frame_sel),
    .o_busy           (busy),
    .o_done           (done),
    .o_corr_go        (corr_go),
    .o_corr_x_offset  (corr_x),
    .o_corr_y_offset  (corr_y),
    .o_corr_frame_sel (corr_frame_sel),
    .i_corr_sum       (corr_sum),
    .i_corr_done      (corr_done),
    .o_best_x         (best_x),
    .o_best_y         (best_y),
    .o_best_sum       (best_sum),
    .o_result_valid   (result_valid)
  );

  // Correlator model: scripted sum after 1..40 cycles; garbage on corr_sum otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      corr_done <= 1'b0;
      corr_sum  <= '0;
    end else begin
      corr_done <= 1'b0;
      corr_sum  <= SW'($urandom);
      if (corr_go) begin
        m_busy <= 1'b1;
        m_cnt  <= int'($urandom_range(40, 1));
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          corr_done <= 1'b1;
          corr_sum  <= sums[{corr_y, corr_x}];
          m_busy    <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (corr_go) go_cnt <= go_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_sums(input int dflt);
    for (int i = 0; i < 16; i++) sums[i] = SW'(dflt);
  endtask

  task automatic start_sweep(input logic fsel, input logic with_abort);
    @(negedge clk);
    frame_sel = fsel;
    start     = 1'b1;
    abort     = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_go_at(input int x, input int y);
    int n = 0;
    while (!(corr_go && corr_x == OW'(x) && corr_y == OW'(y)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("go_seen", {31'd0, corr_go}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; frame_sel = 1'b0;
    fill_sums(100);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_go", {31'd0, corr_go}, 0);
    check_eq("rst_best_sum", {21'd0, best_sum}, 32'h7FF);
    check_eq("rst_valid", {31'd0, result_valid}, 0);
    check_eq("rst_best_x", {30'd0, best_x}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: single minimum at (2,1); start with abort together must still start
    fill_sums(100);
    sums[1*4+2] = 7;
    g0 = go_cnt; d0 = done_cnt;
    start_sweep(1'b0, 1'b1);
    check_eq("t1_busy", {31'd0, busy}, 1);
    wait_idle("t1_end");
    check_eq("t1_gos", go_cnt - g0, 16);
    check_eq("t1_dones", done_cnt - d0, 1);
    check_eq("t1_bx", {30'd0, best_x}, 2);
    check_eq("t1_by", {30'd0, best_y}, 1);
    check_eq("t1_bsum", {21'd0, best_sum}, 7);
    check_eq("t1_valid", {31'd0, result_valid}, 1);

    // 2+4: tie keeps raster-first; mid-sweep start and frame_sel change ignored
    fill_sums(9);
    sums[0*4+1] = 5;
    sums[2*4+3] = 5;
    g0 = go_cnt; d0 = done_cnt;
    start_sweep(1'b1, 1'b0);
    wait_go_at(1, 1);
    @(negedge clk);
    frame_sel = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_fsel_mid", {31'd0, corr_frame_sel}, 1);
    wait_idle("t2_end");
    check_eq("t2_gos", go_cnt - g0, 16);
    check_eq("t2_dones", done_cnt - d0, 1);
    check_eq("t2_bx", {30'd0, best_x}, 1);
    check_eq("t2_by", {30'd0, best_y}, 0);
    check_eq("t2_bsum", {21'd0, best_sum}, 5);
    check_eq("t4_fsel_end", {31'd0, corr_frame_sel}, 1);

    // 3: abort in WAIT of (1,1) drains, no done, best_* retained
    g0 = go_cnt; d0 = done_cnt;
    start_sweep(1'b0, 1'b0);
    wait_go_at(1, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t3_drain_busy", {31'd0, busy}, 1);
    wait_idle("t3_end");
    check_eq("t3_model_idle", {31'd0, m_busy}, 0);
    check_eq("t3_gos", go_cnt - g0, 6);
    check_eq("t3_dones", done_cnt - d0, 0);
    check_eq("t3_bx", {30'd0, best_x}, 1);
    check_eq("t3_by", {30'd0, best_y}, 0);
    check_eq("t3_bsum", {21'd0, best_sum}, 5);
    check_eq("t3_valid", {31'd0, result_valid}, 0);

    // 6: zero sum at (0,1)
    fill_sums(50);
    sums[1*4+0] = 0;
    g0 = go_cnt; d0 = done_cnt;
    start_sweep(1'b0, 1'b0);
    wait_idle("t6_end");
`ifdef ZERO_SUM_EXIT_EN
    check_eq("t6_gos", go_cnt - g0, 5);
`else
    check_eq("t6_gos", go_cnt - g0, 16);
`endif
    check_eq("t6_dones", done_cnt - d0, 1);
    check_eq("t6_bx", {30'd0, best_x}, 0);
    check_eq("t6_by", {30'd0, best_y}, 1);
    check_eq("t6_bsum", {21'd0, best_sum}, 0);
    check_eq("t6_valid", {31'd0, result_valid}, 1);

    // 5: async reset while in WAIT
    d0 = done_cnt;
    start_sweep(1'b1, 1'b0);
    wait_go_at(0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_go", {31'd0, corr_go}, 0);
    check_eq("t5_busy", {31'd0, busy}, 0);
    check_eq("t5_bsum", {21'd0, best_sum}, 32'h7FF);
    check_eq("t5_valid", {31'd0, result_valid}, 0);
    check_eq("t5_fsel", {31'd0, corr_frame_sel}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_dones", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
